// File: rtl/alu_issue_stage_pkg.sv
// Shared widths, bubble opcode and ALU control payload for the decode/execute issue stage.
package alu_issue_stage_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned OPER_W     = 4;

   localparam logic [OPER_W-1:0] OPER_NOP = 4'b0000;

   typedef struct packed {
      logic [OPER_W-1:0] oper;
      logic              inv_a;
      logic              inv_b;
      logic              cin;
      logic              sign;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_fwd_sel.sv
// Operand forwarding select: EX/MEM over MEM/WB over the stored register-file value.
module alu_issue_stage_fwd_sel #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] src_reg,
   input  logic [DATA_WIDTH-1:0] stored_data,
   input  logic                  exmem_wr_en,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_wr_en,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] data_c,
   output logic                  memwb_hit_c
);

   logic exmem_hit_c;

   assign exmem_hit_c = en & exmem_wr_en & (exmem_rd == src_reg);
   assign memwb_hit_c = en & memwb_wr_en & (memwb_rd == src_reg);

   assign data_c = exmem_hit_c ? exmem_result :
                   memwb_hit_c ? memwb_result : stored_data;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/execute pipeline register for the 16-bit ALU with result forwarding,
// load-use hazard detection, stall hold and flush/bubble insertion.
module alu_issue_stage #(
   parameter int unsigned DATA_WIDTH = alu_issue_stage_pkg::DATA_WIDTH,
   parameter int unsigned REG_ADDR_W = alu_issue_stage_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic [DATA_WIDTH-1:0] id_rs_data,
   input  logic [DATA_WIDTH-1:0] id_rt_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic                  id_use_imm,
   input  logic [3:0]            id_oper,
   input  logic                  id_invA,
   input  logic                  id_invB,
   input  logic                  id_cin,
   input  logic                  id_sign,
   input  logic                  id_wr_en,
   input  logic                  id_is_load,
   input  logic                  stall_in,
   input  logic                  flush,
   input  logic                  exmem_wr_en,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_wr_en,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic                  ex_valid,
   output logic [DATA_WIDTH-1:0] ex_InA,
   output logic [DATA_WIDTH-1:0] ex_InB,
   output logic [3:0]            ex_Oper,
   output logic                  ex_invA,
   output logic                  ex_invB,
   output logic                  ex_Cin,
   output logic                  ex_sign,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_wr_en,
   output logic                  ex_is_load,
   output logic                  hazard_stall
);

   import alu_issue_stage_pkg::*;

   logic                  valid_q,   valid_d;
   alu_ctrl_t             ctrl_q,    ctrl_d;
   logic [REG_ADDR_W-1:0] rd_q,      rd_d;
   logic                  wr_en_q,   wr_en_d;
   logic                  is_load_q, is_load_d;
   logic [REG_ADDR_W-1:0] rs_q,      rs_d;
   logic [REG_ADDR_W-1:0] rt_q,      rt_d;
   logic                  rs_used_q, rs_used_d;
   logic                  rt_used_q, rt_used_d;
   logic                  use_imm_q, use_imm_d;
   logic [DATA_WIDTH-1:0] a_q,       a_d;
   logic [DATA_WIDTH-1:0] b_q,       b_d;

   logic                  a_memwb_hit_c;
   logic                  b_memwb_hit_c;

   // Load in EX whose destination is read by the instruction in decode.
   assign hazard_stall = valid_q & is_load_q & wr_en_q & id_valid & ~flush &
                         ((id_rs_used & (id_rs == rd_q)) |
                          (id_rt_used & ~id_use_imm & (id_rt == rd_q)));

   alu_issue_stage_fwd_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_a (
      .en           (valid_q & rs_used_q),
      .src_reg      (rs_q),
      .stored_data  (a_q),
      .exmem_wr_en  (exmem_wr_en),
      .exmem_rd     (exmem_rd),
      .exmem_result (exmem_result),
      .memwb_wr_en  (memwb_wr_en),
      .memwb_rd     (memwb_rd),
      .memwb_result (memwb_result),
      .data_c       (ex_InA),
      .memwb_hit_c  (a_memwb_hit_c)
   );

   // An immediate B operand is never replaced by a forwarded result.
   alu_issue_stage_fwd_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_b (
      .en           (valid_q & rt_used_q & ~use_imm_q),
      .src_reg      (rt_q),
      .stored_data  (b_q),
      .exmem_wr_en  (exmem_wr_en),
      .exmem_rd     (exmem_rd),
      .exmem_result (exmem_result),
      .memwb_wr_en  (memwb_wr_en),
      .memwb_rd     (memwb_rd),
      .memwb_result (memwb_result),
      .data_c       (ex_InB),
      .memwb_hit_c  (b_memwb_hit_c)
   );

   // Next stage contents: bubble by default, then hold or capture.
   always_comb begin
      valid_d     = 1'b0;
      ctrl_d      = '0;
      ctrl_d.oper = OPER_NOP;
      rd_d        = '0;
      wr_en_d     = 1'b0;
      is_load_d   = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      rs_used_d   = 1'b0;
      rt_used_d   = 1'b0;
      use_imm_d   = 1'b0;
      a_d         = '0;
      b_d         = '0;

      if (!flush && stall_in) begin
         valid_d   = valid_q;
         ctrl_d    = ctrl_q;
         rd_d      = rd_q;
         wr_en_d   = wr_en_q;
         is_load_d = is_load_q;
         rs_d      = rs_q;
         rt_d      = rt_q;
         rs_used_d = rs_used_q;
         rt_used_d = rt_used_q;
         use_imm_d = use_imm_q;
         // Retiring MEM/WB value would otherwise vanish while we hold.
         a_d       = a_memwb_hit_c ? memwb_result : a_q;
         b_d       = b_memwb_hit_c ? memwb_result : b_q;
      end else if (!flush && !hazard_stall && id_valid) begin
         valid_d     = 1'b1;
         ctrl_d.oper = id_oper;
         ctrl_d.inv_a = id_invA;
         ctrl_d.inv_b = id_invB;
         ctrl_d.cin  = id_cin;
         ctrl_d.sign = id_sign;
         rd_d        = id_rd;
         wr_en_d     = id_wr_en;
         is_load_d   = id_is_load;
         rs_d        = id_rs;
         rt_d        = id_rt;
         rs_used_d   = id_rs_used;
         rt_used_d   = id_rt_used;
         use_imm_d   = id_use_imm;
         a_d         = id_rs_data;
         b_d         = id_use_imm ? id_imm : id_rt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rd_q      <= '0;
         wr_en_q   <= 1'b0;
         is_load_q <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         rs_used_q <= 1'b0;
         rt_used_q <= 1'b0;
         use_imm_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rd_q      <= rd_d;
         wr_en_q   <= wr_en_d;
         is_load_q <= is_load_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rs_used_q <= rs_used_d;
         rt_used_q <= rt_used_d;
         use_imm_q <= use_imm_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_Oper    = ctrl_q.oper;
   assign ex_invA    = ctrl_q.inv_a;
   assign ex_invB    = ctrl_q.inv_b;
   assign ex_Cin     = ctrl_q.cin;
   assign ex_sign    = ctrl_q.sign;
   assign ex_rd      = rd_q;
   assign ex_wr_en   = wr_en_q;
   assign ex_is_load = is_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [2:0]  id_rs, id_rt, id_rd;
   logic        id_rs_used, id_rt_used;
   logic [15:0] id_rs_data, id_rt_data, id_imm;
   logic        id_use_imm;
   logic [3:0]  id_oper;
   logic        id_invA, id_invB, id_cin, id_sign;
   logic        id_wr_en, id_is_load;
   logic        stall_in, flush;
   logic        exmem_wr_en, memwb_wr_en;
   logic [2:0]  exmem_rd, memwb_rd;
   logic [15:0] exmem_result, memwb_result;
   logic        ex_valid;
   logic [15:0] ex_InA, ex_InB;
   logic [3:0]  ex_Oper;
   logic        ex_invA, ex_invB, ex_Cin, ex_sign;
   logic [2:0]  ex_rd;
   logic        ex_wr_en, ex_is_load;
   logic        hazard_stall;

   int errors = 0;
   int checks = 0;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_oper(id_oper),
      .id_invA(id_invA), .id_invB(id_invB), .id_cin(id_cin), .id_sign(id_sign),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .stall_in(stall_in), .flush(flush),
      .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_InA(ex_InA), .ex_InB(ex_InB), .ex_Oper(ex_Oper),
      .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_Cin(ex_Cin), .ex_sign(ex_sign),
      .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .hazard_stall(hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The instruction currently sitting in the execute slot, as the model sees it.
   typedef struct packed {
      bit        v;
      bit [2:0]  rs, rt, rd;
      bit        rsu, rtu, imm, wr, ld;
      bit [15:0] a, b;
      bit [3:0]  op;
      bit        ia, ib, ci, sg;
   } minst_t;

   minst_t m = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [15:0] m_operand(input bit reads, input bit [2:0] r, input bit [15:0] d);
      if (reads && exmem_wr_en && exmem_rd == r) return exmem_result;
      if (reads && memwb_wr_en && memwb_rd == r) return memwb_result;
      return d;
   endfunction

   function automatic bit m_hazard();
      bit reads_rd;
      reads_rd = (id_rs_used && id_rs == m.rd) || (id_rt_used && !id_use_imm && id_rt == m.rd);
      return m.v && m.ld && m.wr && id_valid && !flush && reads_rd;
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      bit hz;
      hz = m_hazard();
      if (rst || flush) m = '0;
      else if (stall_in) begin
         if (m.v && m.rsu && memwb_wr_en && memwb_rd == m.rs) m.a = memwb_result;
         if (m.v && m.rtu && !m.imm && memwb_wr_en && memwb_rd == m.rt) m.b = memwb_result;
      end else if (hz || !id_valid) m = '0;
      else begin
         m.v = 1; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
         m.rsu = id_rs_used; m.rtu = id_rt_used; m.imm = id_use_imm;
         m.wr = id_wr_en; m.ld = id_is_load;
         m.a = id_rs_data; m.b = id_use_imm ? id_imm : id_rt_data;
         m.op = id_oper; m.ia = id_invA; m.ib = id_invB; m.ci = id_cin; m.sg = id_sign;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle_check();
      #3;
      check("ex_valid", 32'(ex_valid), 32'(m.v));
      check("ex_InA", 32'(ex_InA), 32'(m_operand(m.v && m.rsu, m.rs, m.a)));
      check("ex_InB", 32'(ex_InB), 32'(m_operand(m.v && m.rtu && !m.imm, m.rt, m.b)));
      check("ctrl", 32'({ex_Oper, ex_invA, ex_invB, ex_Cin, ex_sign}),
            32'({m.op, m.ia, m.ib, m.ci, m.sg}));
      check("dest", 32'({ex_rd, ex_wr_en, ex_is_load}), 32'({m.rd, m.wr, m.ld}));
      check("hazard_stall", 32'(hazard_stall), 32'(m_hazard()));
   endtask

   task automatic idle();
      rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_rs_used = 0; id_rt_used = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_use_imm = 0; id_oper = 0;
      id_invA = 0; id_invB = 0; id_cin = 0; id_sign = 0;
      id_wr_en = 0; id_is_load = 0; stall_in = 0; flush = 0;
      exmem_wr_en = 0; exmem_rd = 0; exmem_result = 0;
      memwb_wr_en = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic present(input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] rd,
                          input bit [15:0] a, input bit [15:0] b, input bit ld);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_used = 1; id_rt_used = 1; id_rs_data = a; id_rt_data = b;
      id_use_imm = 0; id_oper = 4'h4; id_wr_en = 1; id_is_load = ld;
   endtask

   task automatic randomize_inputs();
      rst = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 4) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 3'($urandom); id_rt = 3'($urandom); id_rd = 3'($urandom);
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
      id_use_imm = ($urandom_range(0, 3) == 0);
      id_oper = 4'($urandom);
      id_invA = 1'($urandom); id_invB = 1'($urandom);
      id_cin = 1'($urandom); id_sign = 1'($urandom);
      id_wr_en = 1'($urandom); id_is_load = ($urandom_range(0, 2) == 0);
      exmem_wr_en = 1'($urandom); exmem_rd = 3'($urandom); exmem_result = 16'($urandom);
      memwb_wr_en = 1'($urandom); memwb_rd = 3'($urandom); memwb_result = 16'($urandom);
   endtask

   initial begin
      idle();
      rst = 1;
      cycle();
      idle();
      settle_check();
      check("reset ex_valid", 32'(ex_valid), 32'd0);
      check("reset ex_Oper", 32'(ex_Oper), 32'd0);

      // Plain ADD, no forwarding sources.
      present(3'd1, 3'd2, 3'd5, 16'h0005, 16'h0003, 1'b0);
      settle_check();
      cycle();
      idle();
      settle_check();
      check("add InA", 32'(ex_InA), 32'h0005);
      check("add InB", 32'(ex_InB), 32'h0003);
      check("add valid", 32'(ex_valid), 32'd1);

      // EX/MEM beats MEM/WB on the same register.
      present(3'd3, 3'd0, 3'd6, 16'h0000, 16'h0000, 1'b0);
      id_rt_used = 0;
      cycle();
      idle();
      exmem_wr_en = 1; exmem_rd = 3'd3; exmem_result = 16'h1111;
      memwb_wr_en = 1; memwb_rd = 3'd3; memwb_result = 16'h2222;
      settle_check();
      check("fwd exmem", 32'(ex_InA), 32'h1111);
      exmem_wr_en = 0;
      settle_check();
      check("fwd memwb", 32'(ex_InA), 32'h2222);

      // Load-use: one bubble, then the held instruction is taken.
      idle();
      present(3'd0, 3'd0, 3'd4, 16'h0000, 16'h0000, 1'b1);
      cycle();
      idle();
      present(3'd4, 3'd1, 3'd2, 16'h0042, 16'h0001, 1'b0);
      settle_check();
      check("hazard on", 32'(hazard_stall), 32'd1);
      cycle();
      settle_check();
      check("hazard bubble", 32'(ex_valid), 32'd0);
      check("hazard off", 32'(hazard_stall), 32'd0);
      cycle();
      idle();
      settle_check();
      check("hazard capture", 32'({ex_valid, ex_rd}), 32'({1'b1, 3'd2}));

      // Stall must keep a value that MEM/WB presented only once.
      present(3'd6, 3'd0, 3'd1, 16'h0001, 16'h0000, 1'b0);
      id_rt_used = 0;
      cycle();
      idle();
      stall_in = 1; memwb_wr_en = 1; memwb_rd = 3'd6; memwb_result = 16'hBEEF;
      settle_check();
      cycle();
      memwb_wr_en = 0; memwb_result = 16'h0000;
      settle_check();
      cycle();
      cycle();
      stall_in = 0;
      settle_check();
      check("stall keeps fwd", 32'(ex_InA), 32'hBEEF);

      // Flush wins over stall.
      present(3'd1, 3'd1, 3'd1, 16'h1234, 16'h5678, 1'b0);
      stall_in = 1; flush = 1;
      cycle();
      idle();
      settle_check();
      check("flush valid", 32'(ex_valid), 32'd0);
      check("flush wr_en", 32'(ex_wr_en), 32'd0);

      // Immediate B: no hazard against a load to rt, and no forwarding onto B.
      present(3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000, 1'b1);
      cycle();
      idle();
      present(3'd2, 3'd5, 3'd3, 16'h0007, 16'h1234, 1'b0);
      id_rs_used = 0; id_use_imm = 1; id_imm = 16'hFFF0;
      settle_check();
      check("imm no hazard", 32'(hazard_stall), 32'd0);
      cycle();
      idle();
      exmem_wr_en = 1; exmem_rd = 3'd5; exmem_result = 16'hAAAA;
      memwb_wr_en = 1; memwb_rd = 3'd5; memwb_result = 16'hBBBB;
      settle_check();
      check("imm InB", 32'(ex_InB), 32'hFFF0);

      // Reset during stall leaves nothing behind.
      idle();
      present(3'd1, 3'd2, 3'd3, 16'h0101, 16'h0202, 1'b0);
      cycle();
      stall_in = 1; rst = 1;
      cycle();
      idle();
      settle_check();
      check("rst mid stall", 32'(ex_valid), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         cycle();
         randomize_inputs();
         settle_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/execute pipeline register feeding the 16-bit ALU. It captures decoded operands and ALU controls, forwards results from EX/MEM and MEM/WB onto the ALU inputs, and detects load-use hazards. It handles stall, flush and bubble insertion so that the ALU sees stable, correct `InA`/`InB`/control values every cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand/result width
- `REG_ADDR_W`, 3, register specifier width

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  REG_ADDR_W  source A, source B and destination specifiers
- `id_rs_used`, `id_rt_used`  in  1  source actually read
- `id_rs_data`, `id_rt_data`  in  DATA_WIDTH  register-file read data
- `id_imm`  in  DATA_WIDTH  sign/zero-extended immediate
- `id_use_imm`  in  1  B operand is `id_imm`
- `id_oper`  in  4  ALU `Oper`
- `id_invA`, `id_invB`, `id_cin`, `id_sign`  in  1 each  ALU controls
- `id_wr_en`  in  1  instruction writes `id_rd`
- `id_is_load`  in  1  instruction is a memory load
- `stall_in`  in  1  downstream stall; hold stage contents
- `flush`  in  1  squash stage contents (branch mispredict)
- `exmem_wr_en`, `exmem_rd`, `exmem_result`  in  1 / REG_ADDR_W / DATA_WIDTH  EX/MEM forwarding source
- `memwb_wr_en`, `memwb_rd`, `memwb_result`  in  1 / REG_ADDR_W / DATA_WIDTH  MEM/WB forwarding source
- `ex_valid`  out  1  stage holds a real instruction
- `ex_InA`, `ex_InB`  out  DATA_WIDTH  forwarded ALU operands
- `ex_Oper`  out  4; `ex_invA`, `ex_invB`, `ex_Cin`, `ex_sign`  out  1 each  registered ALU controls
- `ex_rd`  out  REG_ADDR_W; `ex_wr_en`, `ex_is_load`  out  1  registered destination info
- `hazard_stall`  out  1  load-use hazard; decode must hold

## Operation
- Update priority each edge: `rst` > `flush` > `stall_in` > `hazard_stall` > capture.
- `rst`: all registered outputs 0, so `ex_valid` = 0 and `ex_Oper` = 4'b0000.
- `flush`: load a bubble. `ex_valid`, `ex_wr_en` and `ex_is_load` go to 0. Other fields are don't-care and are driven to 0. `flush` wins over `stall_in`.
- `stall_in`: hold every field. Exception: the stored A/B data is refreshed with `memwb_result` when the MEM/WB forwarding match below is true. This keeps a value forwarded from a retiring instruction from being lost.
- `hazard_stall` (and no `stall_in`): load a bubble. Decode holds and re-presents the same instruction.
- Capture: latch all `id_*` fields. Stored B = `id_use_imm ? id_imm : id_rt_data`. A bubble is latched when `id_valid` = 0.
- Forwarding (combinational from stored state):
  - For each source s in {A, B}, match_exmem = `ex_valid & s_used & exmem_wr_en & exmem_rd == s_reg`. match_memwb is defined the same way.
  - Output = exmem_result if match_exmem, else memwb_result if match_memwb, else stored data. EX/MEM has priority.
  - B never forwards when the stored imm flag is set.
- `hazard_stall` = `ex_valid & ex_is_load & ex_wr_en & id_valid & ~flush & ((id_rs_used & id_rs == ex_rd) | (id_rt_used & ~id_use_imm & id_rt == ex_rd))`.
- Register 0 is an ordinary register; no special casing.

## Timing
- Decode-to-ALU latency: 1 cycle. Values captured at edge N appear on `ex_*` after edge N.
- `ex_InA`/`ex_InB` are combinational from stored state plus the forwarding inputs, within the same cycle.
- `hazard_stall` is combinational from `id_*` and stored state. It asserts for exactly one cycle per load-use pair, because the bubble clears `ex_is_load`.
- A stalled stage asserts `hazard_stall` continuously if the condition holds. Decode must treat `stall_in | hazard_stall` as hold.
- When `rst` is asserted mid-stall or mid-hazard, the next cycle shows the reset values with no residual hold.

## Structure
- The shared package holds `DATA_WIDTH`, `REG_ADDR_W`, and the `OPER_NOP` = 4'b0000 constant used for bubbles.
- One sub-module, `fwd_sel`, contains the two match comparators and the 3:1 priority mux. It is instantiated twice, once for A and once for B; B has its enable gated by the imm flag.

## Test plan
- Reset, then capture ADD with rs=1 (0x0005), rt=2 (0x0003), no matching writers: `ex_InA` = 0x0005 and `ex_InB` = 0x0003 one cycle later, `ex_valid` = 1.
- Stored rs=3; `exmem_wr_en`=1, `exmem_rd`=3, `exmem_result`=0x1111; `memwb_wr_en`=1, `memwb_rd`=3, `memwb_result`=0x2222: `ex_InA` = 0x1111. With EX/MEM deasserted: `ex_InA` = 0x2222.
- Stage holds load to rd=4; decode presents rs=4, `id_rs_used`=1: `hazard_stall` = 1. The next cycle `ex_valid` = 0 and `hazard_stall` = 0. The following cycle captures the instruction.
- `stall_in`=1 for 3 cycles while MEM/WB writes rd=rs with 0xBEEF in cycle 1 only: after the stall releases, `ex_InA` still = 0xBEEF.
- `flush` and `stall_in` asserted together: next cycle `ex_valid` = 0 and `ex_wr_en` = 0.
- `id_use_imm`=1, `id_imm`=0xFFF0, rt matches `exmem_rd`: `ex_InB` = 0xFFF0 and no hazard is raised.
